// File: rtl/disp_scheduler.sv
// Round-robin display scheduler for the seven-segment converter.
// Rotates over enabled sources with dwell, hold, manual advance and priority jump.
module disp_scheduler #(
    parameter int N_SRC      = 4,
    parameter int DWELL      = 50_000_000,
    parameter int PRIO_SRC   = N_SRC - 1,
    parameter int PRIO_DWELL = 2 * DWELL
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [8*N_SRC-1:0]       src_value,
    input  logic [N_SRC-1:0]         src_en,
    input  logic                     hold,
    input  logic                     next,
    input  logic                     prio_req,
    output logic [7:0]               disp_value,
    output logic [$clog2(N_SRC)-1:0] disp_src,
    output logic                     disp_valid,
    output logic                     slot_start
);

    localparam int IW   = $clog2(N_SRC);
    localparam int MAXD = (DWELL > PRIO_DWELL) ? DWELL : PRIO_DWELL;
    localparam int CW   = $clog2(MAXD);

    localparam logic [CW-1:0] DW_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] PR_LAST = CW'(PRIO_DWELL - 1);
    localparam logic [IW-1:0] P_IDX   = IW'(PRIO_SRC);
    localparam logic [IW-1:0] TOP_IDX = IW'(N_SRC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        PRIO
    } state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] ret_idx, ret_nxt;
    logic [IW-1:0] load_idx;
    logic          load, go_idle;
    logic [IW:0]   sel, low, back;

    // MSB flags a hit; offset N_SRC wraps back to idx itself
    function automatic logic [IW:0] find_after(
        input logic [IW-1:0]    idx,
        input logic [N_SRC-1:0] en
    );
        logic [IW:0] r;
        int          j;
        r = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            j = (int'(idx) + k) % N_SRC;
            if (en[IW'(j)]) r = {1'b1, IW'(j)};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        cnt_nxt   = cnt;
        ret_nxt   = ret_idx;
        load      = 1'b0;
        load_idx  = disp_src;
        go_idle   = 1'b0;
        sel       = find_after(disp_src, src_en);
        low       = find_after(TOP_IDX, src_en);
        back      = find_after(ret_idx, src_en);
        unique case (state)
            IDLE: begin
                if (prio_req) begin
                    nxt_state = PRIO;
                    load      = 1'b1;
                    load_idx  = P_IDX;
                end else if (low[IW]) begin
                    nxt_state = SHOW;
                    load      = 1'b1;
                    load_idx  = low[IW-1:0];
                end
            end
            SHOW: begin
                if (prio_req) begin
                    nxt_state = PRIO;
                    load      = 1'b1;
                    load_idx  = P_IDX;
                    ret_nxt   = disp_src;
                end else if (next || !src_en[disp_src] ||
                             (cnt == DW_LAST && !hold)) begin
                    if (sel[IW]) begin
                        load     = 1'b1;
                        load_idx = sel[IW-1:0];
                    end else begin
                        nxt_state = IDLE;
                        go_idle   = 1'b1;
                    end
                end else if (!hold) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRIO: begin
                if (prio_req) begin
                    load     = 1'b1;
                    load_idx = P_IDX;
                end else if (next || (cnt == PR_LAST && !hold)) begin
                    if (back[IW]) begin
                        nxt_state = SHOW;
                        load      = 1'b1;
                        load_idx  = back[IW-1:0];
                    end else begin
                        nxt_state = IDLE;
                        go_idle   = 1'b1;
                    end
                end else if (!hold) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (load || go_idle) cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            ret_idx    <= '0;
            disp_value <= '0;
            disp_src   <= '0;
            disp_valid <= 1'b0;
            slot_start <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            ret_idx    <= ret_nxt;
            slot_start <= load;
            disp_valid <= (nxt_state != IDLE);
            if (load) begin
                disp_value <= src_value[{load_idx, 3'b000} +: 8];
                disp_src   <= load_idx;
            end else if (go_idle) begin
                disp_value <= '0;
            end
        end
    end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Time-multiplexes the signed 8-bit seven-segment converter on the FPGA board between up to N_SRC 8-bit signed sources, such as operand A, operand B and the Booth result byte. It rotates round-robin over the enabled sources, dwelling a programmable number of cycles on each. Manual advance, freeze and a priority jump (e.g. on multiplier done) are supported. Its registered outputs drive the converter's Svalue input and the source-indicator LEDs.

## Interface
- N_SRC, 4, number of sources (2..8)
- DWELL, 50_000_000, cycles each source is shown during rotation (≥2)
- PRIO_SRC, N_SRC-1, source index shown on a priority request
- PRIO_DWELL, 2*DWELL, cycles the priority source is shown (≥2)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- src_value  in  8*N_SRC  signed sources, source i at [8i+7:8i]
- src_en  in  N_SRC  source i takes part in rotation when 1
- hold  in  1  level; freezes dwell timeout
- next  in  1  single-cycle pulse (already debounced); advance now
- prio_req  in  1  single-cycle pulse; jump to PRIO_SRC
- disp_value  out  8  signed value to converter (registered)
- disp_src  out  $clog2(N_SRC)  index of shown source (registered)
- disp_valid  out  1  1 when a source is being shown
- slot_start  out  1  one-cycle pulse when a new slot is loaded

## Operation
- States:
  - IDLE: nothing shown, disp_valid=0.
  - SHOW: rotation slot.
  - PRIO: priority slot.
- Slot load: latch src_value[cur] into disp_value, set disp_src, clear dwell counter, pulse slot_start. disp_value holds stable for the whole slot; it does not track a live source.
- Next-source search: first enabled index after the current one, ascending, wrapping past N_SRC-1 to 0.
  - If the current index is the only enabled one, it is selected again. The slot reloads, slot_start pulses and the counter restarts.
- IDLE→SHOW: when any src_en bit is 1, load the lowest enabled index.
- SHOW:
  - The counter increments each cycle.
  - At DWELL-1 with hold=0, advance.
  - With hold=1 the counter freezes, at DWELL-1 or wherever it is.
  - next advances regardless of hold.
  - If src_en[disp_src] drops, advance on the next cycle.
  - If src_en becomes all zero, go to IDLE: disp_valid=0, disp_value=0.
- PRIO:
  - Entered from IDLE, SHOW or PRIO on prio_req. Loads PRIO_SRC even if it is not enabled.
  - prio_req while already in PRIO restarts the slot.
  - After PRIO_DWELL cycles, return to SHOW and load the next enabled source after the index shown before entering PRIO. If none is enabled, go to IDLE.
  - hold freezes the PRIO counter.
  - next in PRIO exits immediately, as a timeout would.
- Same-cycle priority: prio_req > next > src_en drop > dwell timeout.
- Arithmetic:
  - Counter width is $clog2(max(DWELL,PRIO_DWELL)).
  - Index arithmetic is modulo N_SRC.
  - disp_value is passed through unmodified; -128 is legal.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, counter=0.
  - disp_value=0, disp_src=0, disp_valid=0, slot_start=0.
  - The saved return index is 0.
- All outputs are registered. An event (next, prio_req, timeout, enable change) seen at edge k produces new disp_* and the slot_start pulse after edge k+1, i.e. one cycle of latency.
- A slot lasts exactly DWELL (or PRIO_DWELL) cycles of disp_valid, measured from slot_start to the next slot_start, when hold=0 and no events occur.
- A source value changing mid-slot has no effect until the next slot load.
- Reset mid-slot drops to the reset state at once. After rst_n rises, the first load occurs one cycle after the first edge that sees any src_en bit set.

## Test plan
Bench parameters: N_SRC=4, DWELL=4, PRIO_DWELL=6, PRIO_SRC=3. Values: src0=-128, src1=5, src2=127, src3=-1.

1. Rotation with wrap: src_en=1111, no events → disp_src sequence 0,1,2,3,0, each held 4 cycles; disp_value -128,5,127,-1; slot_start pulses every 4 cycles.
2. Sparse enable and single source:
   - src_en=0101 → sequence 0,2,0.
   - src_en=0100 → src 2 reloads every 4 cycles with a slot_start pulse each time.
   - src_en=0000 mid-slot → disp_valid=0 and disp_value=0 one cycle later.
3. Hold and next: hold=1 while on src1 for 20 cycles → src1 stays; a next pulse during hold → src2 one cycle later. Releasing hold with the counter frozen at 3 → advance on the next cycle.
4. Priority:
   - prio_req while on src1 → src3 (-1) for 6 cycles, then src2.
   - prio_req and next in the same cycle → PRIO wins.
   - A second prio_req at cycle 4 of PRIO → 6 more cycles.
5. Reset mid-operation: assert rst_n=0 asynchronously mid-slot → all outputs 0 immediately with no clock. Release with src_en=1000 → src3 loaded, disp_valid=1 after one cycle.
6. Enable drop: while on src2, clear src_en[2] → advance to src3 one cycle later. A source value change mid-slot leaves disp_value unchanged until the next slot load.
